uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. Each cycle the receiver presents a valid byte, the block writes it into a circular buffer. Bytes are presented to the CPU/bus side through a show-ahead valid/ready port. It also reports fill level, a sticky overflow flag and an optional fill-threshold interrupt.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥2.
- AW, $clog2(DEPTH), derived pointer width; do not override.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  reset: one clock, synchronous, active-high.
- in_valid  in  1  byte strobe from receiver; every high cycle is one byte.
- in_data  in  8  received byte, qualified by in_valid.
- out_valid  out  1  head byte available (FIFO not empty).
- out_data  out  8  head byte; valid only while out_valid=1.
- out_ready  in  1  consumer accepts head byte when out_valid && out_ready.
- count  out  AW+1  current number of stored bytes, 0..DEPTH.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- thresh  in  AW+1  fill threshold for thresh_irq.
- thresh_irq  out  1  level interrupt: fill at or above threshold.

## Operation
- Storage: DEPTH×8 array. Write pointer wr_ptr and read pointer rd_ptr are each AW+1 bits, with an extra wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (low AW bits equal) && (wrap bits differ).
- count = wr_ptr − rd_ptr, computed modulo 2^(AW+1).
- pop = out_valid && out_ready. rd_ptr advances by 1.
- push = in_valid && (!full || pop). The byte is written at mem[wr_ptr[AW-1:0]] and wr_ptr advances by 1.
- Drop = in_valid && full && !pop. The byte is discarded, pointers are unchanged, and overflow is set.
- Full with simultaneous in_valid and pop: both happen, count stays DEPTH, no overflow.
- Empty with in_valid: no bypass. The byte is stored, and out_valid rises the following cycle.
- Pointer wrap: the low AW bits wrap naturally from DEPTH−1 to 0, and the wrap bit toggles.
- out_data = mem[rd_ptr[AW-1:0]], read combinationally from the array (show-ahead).
- overflow: set on a drop. Cleared by ovf_clr when no drop occurs that cycle. Drop and ovf_clr in the same cycle leave overflow at 1 (set wins).
- thresh_irq = (thresh != 0) && (count >= thresh). It is combinational from the registered count and holds as a level until count falls below thresh.
- Upstream has no back-pressure. The block must never stall in_valid.

## Timing
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0 and overflow=0. After that edge, out_valid=0, count=0, overflow=0 and thresh_irq=0. Array contents are not reset, and out_data is don't-care while out_valid=0.
- Reset mid-operation discards all stored bytes in the same edge. in_valid during rst is ignored.
- Write latency: a byte pushed at edge N is visible on out_valid/out_data after edge N. count reflects it after edge N.
- Pop: the byte is consumed at the edge where out_valid && out_ready. The next head appears after that edge with no bubble.
- Back-to-back pushes and pops every cycle are sustained indefinitely.
- ovf_clr takes effect at the edge where it is sampled high.

## Configuration
- UART_RX_FIFO_THRESH_EN defined: thresh_irq logic is built exactly as described above.
- UART_RX_FIFO_THRESH_EN undefined: the port list is unchanged, thresh is ignored, thresh_irq is tied to 0, and no comparator is synthesized.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with out_ready=0 → count=3 and out_data=0x41. Raise out_ready for 3 cycles → 0x41, 0x42, 0x43 in order, then out_valid=0 and count=0.
- DEPTH=16: push 16 bytes 0x00..0x0F, then push 0xAA with out_ready=0 → count=16, overflow=1, and 0xAA is absent. Drain → 0x00..0x0F. Assert ovf_clr → overflow=0 next cycle.
- At full, push 0x55 in the same cycle as a pop → no overflow, count stays 16, and 0x55 is read last.
- Run 40 bytes with a push and a pop every cycle so the pointers wrap twice → output sequence is identical to input, count stays ≤1, and overflow stays 0.
- thresh=4 with the macro defined: push 3 bytes → thresh_irq=0; push a 4th → thresh_irq=1; pop 1 → thresh_irq=0. thresh=0 → thresh_irq stays 0. Macro undefined → thresh_irq always 0.
- Hold 5 bytes, assert rst for 1 cycle while in_valid=1 with 0x77 → count=0, out_valid=0 and overflow=0 afterwards, and 0x77 is not stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO with show-ahead output, fill count and sticky overflow.
// Define UART_RX_FIFO_THRESH_EN to build the fill-threshold interrupt; otherwise thresh_irq is 0.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic [AW:0]   thresh,
    output logic          thresh_irq
);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic full, pop, push, drop;
    assign out_valid = wr_ptr != rd_ptr;
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;
    assign count = wr_ptr - rd_ptr;
    assign out_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overflow <= drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[AW-1:0]] <= in_data;
    end
`ifdef UART_RX_FIFO_THRESH_EN
    assign thresh_irq = (thresh != '0) && (count >= thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign thresh_irq = 1'b0;
`endif
endmodule
